shared_adder_arbiter: RTL and testbench
=======================================

Name: shared_adder_arbiter

Overview:
- Shares the single A / 1 / -A operand-select mux and its adder between two requesters: port 0 is the ALU issue path, port 1 is the PC/branch unit.
- Arbitrates between the requesters and drives the mux select and operand.
- Samples the mux output, adds it to the requester's X operand, and returns a registered result with flags on one response channel.
- The negator producing -A sits outside this block and is fed from mux_a.

Parameters:
- WIDTH, 32, datapath width; must equal the operand-select mux width (32).
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted (one-cycle pulse)
- req0_op  in  2  port 0 op: 00 ADD, 01 INC, 10 SUB, 11 reserved
- req0_x  in  WIDTH  port 0 X operand
- req0_y  in  WIDTH  port 0 Y operand
- req1_valid, req1_ready, req1_op, req1_x, req1_y  same directions and widths as port 0, for port 1
- mux_a  out  WIDTH  Y operand to the mux A input and to the external negator
- mux_sel  out  2  mux select: 00 = A, 01 = constant 1, 10 = -A
- mux_out  in  WIDTH  mux result
- rsp_valid  out  1  response valid; held until accepted
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  granted port number
- rsp_result  out  WIDTH  X + mux_out, mod 2^WIDTH
- rsp_zero  out  1  rsp_result == 0
- rsp_carry  out  1  carry out of bit WIDTH-1
- rsp_ovf  out  1  signed overflow
- rsp_err  out  1  request used reserved op 11

Behaviour:
- Reset: clk and rst_n are the only clock and reset; rst_n is asynchronous, active-low.
  - State = IDLE; all outputs 0, including mux_sel = 00 and mux_a = 0.
  - last_grant = 1, so port 0 wins first.
  - Reset asserted mid-operation discards the in-flight op and any pending response; no response is emitted for it.
- States:
  - IDLE -> ISSUE when any reqN_valid is high.
  - ISSUE -> EXEC unconditionally.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready is high.
- IDLE cycle:
  - Winner is chosen combinationally; reqN_ready = 1 for the winner only.
  - Winner's op, x, y and id are captured into the issue register on that edge.
  - Round-robin: if both ports are valid, grant the port not equal to last_grant; last_grant updates on every grant.
  - FIXED_PRIO = 1: port 0 wins whenever req0_valid is high.
- ISSUE cycle:
  - mux_a = captured y.
  - mux_sel = op (00 / 01 / 10); op 11 is driven as 11, so the mux outputs 0.
  - mux_sel and mux_a are registered outputs and stay stable through EXEC.
- EXEC cycle:
  - mux_out is sampled at the end of EXEC; the sum and all flags are registered into the response register.
  - Sum = x + mux_out as a WIDTH+1-bit add; bit WIDTH = carry.
  - ovf = (x[MSB] == m[MSB]) && (sum[MSB] != x[MSB]), where m = mux_out.
  - err = (op == 11); the result is still x + 0.
- RESP:
  - rsp_valid = 1; all rsp_* outputs are held stable until rsp_ready.
  - rsp_valid drops the cycle after the handshake.
  - reqN_ready stays 0 outside IDLE; requesters keep valid and operands stable until they see ready.
- Latency: grant edge to rsp_valid is 3 cycles; minimum issue interval is 4 cycles.
- INC ignores y for arithmetic, but mux_a still carries y.
- Simultaneous events:
  - A request arriving during ISSUE, EXEC or RESP waits; no request is lost or reordered within a port.
  - rsp_ready high in the same cycle that rsp_valid rises completes the response in that cycle.
- Wrap-around: 0xFFFFFFFF INC gives 0, carry = 1, zero = 1, ovf = 0.

Decomposition:
- Shared package / include:
  - op codes OP_ADD = 2'b00, OP_INC = 2'b01, OP_SUB = 2'b10, OP_RSV = 2'b11
  - state encodings IDLE / ISSUE / EXEC / RESP
  - WIDTH default
- Sub-module: rr_arbiter2 (two requests, last_grant register, FIXED_PRIO input) -> one-hot grant. The FSM, issue register and response register stay in the top level.

Test Plan:
- Port 0 ADD x = 5, y = 7; mux model returns y -> ready0 pulse, mux_sel = 00, mux_a = 7; 3 cycles later rsp_valid, result = 12, id = 0, all flags 0.
- Port 1 SUB x = 3, y = 5; mux returns -5 -> result = 0xFFFFFFFE, carry = 0, ovf = 0, zero = 0, id = 1.
- Port 0 INC x = 0xFFFFFFFF -> mux_sel = 01, result = 0, carry = 1, zero = 1; then ADD 0x7FFFFFFF + 1 -> ovf = 1.
- Both ports valid continuously for 4 ops, FIXED_PRIO = 0 -> grant order 0, 1, 0, 1. Repeat with FIXED_PRIO = 1 -> 0, 0, 0, 0.
- rsp_ready held 0 for 5 cycles -> rsp_* stable and no new ready issued; ready pulse follows the handshake.
- rst_n low during EXEC -> all outputs 0 immediately; after release, no stale response, and port 0 wins the next tie. Op 11 -> mux_sel = 11, result = x, err = 1.

Source files
------------

// File: rtl/shared_adder_arbiter_pkg.sv
// Shared definitions for the shared adder arbiter: op codes, FSM states, default width.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package shared_adder_arbiter_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_INC = 2'b01,
    OP_SUB = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    EXEC  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/shared_adder_arbiter_if.sv
// Bundles both request ports, the operand-select mux hookup and the response channel.
// Latency: none (wiring only).
// Backpressure: requests by valid/ready pulse, response by valid held until ready.
interface shared_adder_arbiter_if
  import shared_adder_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;

  logic [WIDTH-1:0] mux_a;
  logic [1:0]       mux_sel;
  logic [WIDTH-1:0] mux_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_ovf;
  logic             rsp_err;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    output req0_ready,
    input  req1_valid, req1_op, req1_x, req1_y,
    output req1_ready,
    output mux_a, mux_sel,
    input  mux_out,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf, rsp_err,
    input  rsp_ready
  );

  // Requester / mux / consumer side
  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    input  req0_ready,
    output req1_valid, req1_op, req1_x, req1_y,
    input  req1_ready,
    input  mux_a, mux_sel,
    output mux_out,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/shared_adder_arbiter_rr_arbiter2.sv
// Two-way arbiter: round-robin on last_grant, or port 0 always wins when fixed_prio_i is set.
// Latency: grant is combinational from req_i; last_grant updates on the take edge.
// Backpressure: grant only advances history when take_i is high.
module shared_adder_arbiter_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       fixed_prio_i,
  input  logic       take_i,
  output logic [1:0] gnt_o
);

  logic last_grant_q;
  logic last_grant_d;

  // One-hot grant: on a tie, round-robin favours the port that did not win last time
  always_comb begin
    gnt_o = 2'b00;
    if (fixed_prio_i) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
    end else if (req_i == 2'b11) begin
      gnt_o = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

  // Remember which port won whenever a grant is actually taken
  always_comb begin
    last_grant_d = last_grant_q;
    if (take_i && (gnt_o != 2'b00)) last_grant_d = gnt_o[1];
  end

  // Reset to port 1 so that port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/shared_adder_arbiter.sv
// Shares one A/1/-A operand mux and adder between the ALU issue path (port 0) and PC/branch unit (port 1).
// Latency: 3 cycles from grant to rsp_valid; one op in flight, new grant at most every 4 cycles.
// Backpressure: reqN_ready only pulses in IDLE; response held until rsp_ready, which stalls further grants.
module shared_adder_arbiter
  import shared_adder_arbiter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  shared_adder_arbiter_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q;
  logic             id_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] mux_a_q;
  logic [1:0]       mux_sel_q;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_carry_q;
  logic             rsp_ovf_q;
  logic             rsp_err_q;

  logic [1:0]       gnt;
  logic             idle;
  logic [WIDTH:0]   sum;
  logic             ovf;

  assign idle = (state_q == IDLE);

  shared_adder_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       ({bus.req1_valid, bus.req0_valid}),
    .fixed_prio_i(FIXED_PRIO),
    .take_i      (idle),
    .gnt_o       (gnt)
  );

  // Adder on the sampled mux output; carry is the extra top bit, overflow from sign agreement
  always_comb begin
    sum = {1'b0, x_q} + {1'b0, bus.mux_out};
    ovf = (x_q[MSB] == bus.mux_out[MSB]) && (sum[MSB] != x_q[MSB]);
  end

  // Control FSM with issue register (x, id, mux drive) and response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      x_q          <= '0;
      mux_a_q      <= '0;
      mux_sel_q    <= 2'b00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            // Mux drive is registered here so it is stable through ISSUE and EXEC
            id_q      <= gnt[1];
            x_q       <= gnt[1] ? bus.req1_x  : bus.req0_x;
            mux_a_q   <= gnt[1] ? bus.req1_y  : bus.req0_y;
            mux_sel_q <= gnt[1] ? bus.req1_op : bus.req0_op;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= EXEC;
        end
        EXEC: begin
          // Reserved op drives select 11; the mux yields 0 so the result is just x
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= id_q;
          rsp_result_q <= sum[MSB:0];
          rsp_zero_q   <= (sum[MSB:0] == '0);
          rsp_carry_q  <= sum[WIDTH];
          rsp_ovf_q    <= ovf;
          rsp_err_q    <= (mux_sel_q == OP_RSV);
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is masked by reset so no acceptance is signalled while the block is held
  assign bus.req0_ready = rst_n & idle & gnt[0];
  assign bus.req1_ready = rst_n & idle & gnt[1];

  assign bus.mux_a      = mux_a_q;
  assign bus.mux_sel    = mux_sel_q;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Bench for shared_adder_arbiter: round-robin instance with scoreboard, plus a fixed-priority instance.
// Latency: checks 3-cycle grant-to-response and 1-cycle grant-to-mux-drive.
// Backpressure: exercises rsp_ready stalls and continuously-valid requesters.
module tb_shared_adder_arbiter;
  import shared_adder_arbiter_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } stim_t;

  typedef struct {
    logic         id;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         err;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shared_adder_arbiter_if #(.WIDTH(W)) bus ();
  shared_adder_arbiter_if #(.WIDTH(W)) fbus ();

  shared_adder_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus));
  shared_adder_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(fbus));

  stim_t stim0[$];
  stim_t stim1[$];
  resp_t sb[$];
  resp_t rsp_log[$];
  int    grants[$];
  int    fgrants[$];
  int    checks = 0;
  int    errors = 0;

  logic         acc0 = 1'b0, acc1 = 1'b0, mux_pend = 1'b0, rsp_prev = 1'b0;
  logic [1:0]   pend_sel;
  logic [W-1:0] pend_a;
  int           cyc = 0, t_grant = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    stim_t s;
    s.op = op; s.x = x; s.y = y;
    return s;
  endfunction

  // External operand-select mux with its negator
  function automatic logic [W-1:0] mux_model(input logic [1:0] sel, input logic [W-1:0] a);
    case (sel)
      2'b00:   return a;
      2'b01:   return W'(1);
      2'b10:   return -a;
      default: return '0;
    endcase
  endfunction

  assign bus.mux_out  = mux_model(bus.mux_sel, bus.mux_a);
  assign fbus.mux_out = mux_model(fbus.mux_sel, fbus.mux_a);

  // Reference for the response a request should produce
  function automatic resp_t exp_model(input logic id, input stim_t s);
    resp_t        e;
    logic [W-1:0] m;
    logic [W:0]   sum;
    case (s.op)
      2'b00:   m = s.y;
      2'b01:   m = W'(1);
      2'b10:   m = -s.y;
      default: m = '0;
    endcase
    sum      = {1'b0, s.x} + {1'b0, m};
    e.id     = id;
    e.result = sum[W-1:0];
    e.carry  = sum[W];
    e.zero   = (sum[W-1:0] == '0);
    e.ovf    = (s.x[W-1] == m[W-1]) && (sum[W-1] != s.x[W-1]);
    e.err    = (s.op == 2'b11);
    return e;
  endfunction

  // Port 0 requester: presents the head of stim0 until it is accepted
  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_x = '0; bus.req0_y = '0;
    forever begin
      @(posedge clk); #1;
      if (acc0) stim0.delete(0);
      if (stim0.size() > 0) begin
        bus.req0_valid = 1'b1; bus.req0_op = stim0[0].op; bus.req0_x = stim0[0].x; bus.req0_y = stim0[0].y;
      end else bus.req0_valid = 1'b0;
    end
  end

  // Port 1 requester
  initial begin
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_x = '0; bus.req1_y = '0;
    forever begin
      @(posedge clk); #1;
      if (acc1) stim1.delete(0);
      if (stim1.size() > 0) begin
        bus.req1_valid = 1'b1; bus.req1_op = stim1[0].op; bus.req1_x = stim1[0].x; bus.req1_y = stim1[0].y;
      end else bus.req1_valid = 1'b0;
    end
  end

  // Monitor: pushes expectations on grant, checks mux drive, latency and responses
  always @(negedge clk) begin : mon
    stim_t s;
    resp_t e, r;
    logic  id;
    if (!rst_n) begin
      sb.delete();
      acc0 = 1'b0; acc1 = 1'b0; mux_pend = 1'b0; rsp_prev = 1'b0;
    end else begin
      cyc++;
      acc0 = bus.req0_ready;
      acc1 = bus.req1_ready;
      if (mux_pend) begin
        check("mux_sel", 64'(bus.mux_sel), 64'(pend_sel));
        check("mux_a", 64'(bus.mux_a), 64'(pend_a));
        mux_pend = 1'b0;
      end
      if (acc0 || acc1) begin
        check("ready_both", 64'(acc0 & acc1), 64'd0);
        s  = acc0 ? stim0[0] : stim1[0];
        id = acc1 & ~acc0;
        sb.push_back(exp_model(id, s));
        grants.push_back(int'(id));
        pend_sel = s.op; pend_a = s.y; mux_pend = 1'b1; t_grant = cyc;
      end
      if (bus.rsp_valid && !rsp_prev) check("latency", 64'(cyc - t_grant), 64'd3);
      rsp_prev = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        r.id = bus.rsp_id; r.result = bus.rsp_result; r.zero = bus.rsp_zero;
        r.carry = bus.rsp_carry; r.ovf = bus.rsp_ovf; r.err = bus.rsp_err;
        rsp_log.push_back(r);
        check("rsp_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp_id", 64'(r.id), 64'(e.id));
          check("rsp_result", 64'(r.result), 64'(e.result));
          check("rsp_zero", 64'(r.zero), 64'(e.zero));
          check("rsp_carry", 64'(r.carry), 64'(e.carry));
          check("rsp_ovf", 64'(r.ovf), 64'(e.ovf));
          check("rsp_err", 64'(r.err), 64'(e.err));
        end
      end
    end
  end

  // Fixed-priority instance: both ports valid forever, consumer always ready
  initial begin
    fbus.req0_valid = 1'b1; fbus.req0_op = OP_ADD; fbus.req0_x = W'(1);  fbus.req0_y = W'(2);
    fbus.req1_valid = 1'b1; fbus.req1_op = OP_ADD; fbus.req1_x = W'(10); fbus.req1_y = W'(20);
    fbus.rsp_ready  = 1'b1;
  end

  // Fixed-priority monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (fbus.req0_ready) fgrants.push_back(0);
      if (fbus.req1_ready) fgrants.push_back(1);
      if (fbus.rsp_valid) begin
        check("fp_rsp_id", 64'(fbus.rsp_id), 64'd0);
        check("fp_rsp_result", 64'(fbus.rsp_result), 64'd3);
      end
    end
  end

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (stim0.size() == 0 && stim1.size() == 0 && sb.size() == 0 && !bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_drain"}, 64'(ok), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req0_ready"}, 64'(bus.req0_ready), 64'd0);
    check({tag, "_req1_ready"}, 64'(bus.req1_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
    check({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'd0);
    check({tag, "_rsp_flags"}, 64'({bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_err}), 64'd0);
    check({tag, "_mux_sel"}, 64'(bus.mux_sel), 64'd0);
    check({tag, "_mux_a"}, 64'(bus.mux_a), 64'd0);
  endtask

  // Overall time limit
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin : main
    int  n, ng, ones;
    bit  seen;
    int  exp_rr[4];
    exp_rr = '{0, 1, 0, 1};
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;

    // Reset state, with a request already waiting on port 0
    stim0.push_back(mk(OP_ADD, 32'd5, 32'd7));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD 5 + 7
    drain("add");
    check("add_log_cnt", 64'(rsp_log.size()), 64'd1);
    check("add_result", 64'(rsp_log[0].result), 64'd12);
    check("add_id", 64'(rsp_log[0].id), 64'd0);
    check("add_flags", 64'({rsp_log[0].zero, rsp_log[0].carry, rsp_log[0].ovf, rsp_log[0].err}), 64'd0);

    // SUB 3 - 5 on port 1
    stim1.push_back(mk(OP_SUB, 32'd3, 32'd5));
    drain("sub");
    check("sub_log_cnt", 64'(rsp_log.size()), 64'd2);
    check("sub_result", 64'(rsp_log[1].result), 64'hFFFF_FFFE);
    check("sub_id", 64'(rsp_log[1].id), 64'd1);
    check("sub_flags", 64'({rsp_log[1].zero, rsp_log[1].carry, rsp_log[1].ovf}), 64'd0);

    // Both ports continuously valid, round-robin
    ng = grants.size();
    for (int i = 0; i < 2; i++) begin
      stim0.push_back(mk(OP_ADD, 32'(100 + i), 32'(i)));
      stim1.push_back(mk(OP_SUB, 32'(200 + i), 32'(3 * i)));
    end
    drain("rr");
    check("rr_cnt", 64'(grants.size() - ng), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 64'(grants[ng + i]), 64'(exp_rr[i]));

    // Wrap-around INC and signed overflow ADD
    n = rsp_log.size();
    stim0.push_back(mk(OP_INC, 32'hFFFF_FFFF, 32'h0000_1234));
    stim0.push_back(mk(OP_ADD, 32'h7FFF_FFFF, 32'd1));
    drain("wrap");
    check("inc_result", 64'(rsp_log[n].result), 64'd0);
    check("inc_zc_ovf", 64'({rsp_log[n].zero, rsp_log[n].carry, rsp_log[n].ovf}), 64'b110);
    check("ovf_result", 64'(rsp_log[n + 1].result), 64'h8000_0000);
    check("ovf_flag", 64'(rsp_log[n + 1].ovf), 64'd1);

    // Response stall: port 1 wins the tie, port 0 must wait
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    stim1.push_back(mk(OP_ADD, 32'd100, 32'd23));
    stim0.push_back(mk(OP_ADD, 32'd6, 32'd6));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    check("stall_rsp_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus.rsp_valid), 64'd1);
      check("stall_result", 64'(bus.rsp_result), 64'd123);
      check("stall_id", 64'(bus.rsp_id), 64'd1);
      check("stall_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_hs", 64'(bus.req0_ready), 64'd1);
    drain("stall");

    // Reset during EXEC discards the op; next tie goes to port 0
    ng = grants.size();
    stim0.push_back(mk(OP_SUB, 32'd9, 32'd4));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (grants.size() > ng);
    end
    check("rst_grant_seen", 64'(seen), 64'd1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_quiet("midrst");
    n  = rsp_log.size();
    ng = grants.size();
    stim0.push_back(mk(OP_ADD, 32'd40, 32'd2));
    stim1.push_back(mk(OP_ADD, 32'd50, 32'd5));
    @(posedge clk); #1 rst_n = 1'b1;
    drain("postrst");
    check("postrst_rsp_cnt", 64'(rsp_log.size() - n), 64'd2);
    check("postrst_first_grant", 64'(grants[ng]), 64'd0);
    check("postrst_result", 64'(rsp_log[n].result), 64'd42);
    check("postrst_id", 64'(rsp_log[n].id), 64'd0);

    // Reserved op: select 11, result is x, err set
    n = rsp_log.size();
    stim0.push_back(mk(OP_RSV, 32'h0000_ABCD, 32'h0000_0055));
    drain("rsv");
    check("rsv_result", 64'(rsp_log[n].result), 64'h0000_ABCD);
    check("rsv_err", 64'(rsp_log[n].err), 64'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);

    // Fixed priority: port 0 always wins while it stays valid
    check("fp_cnt_ge4", 64'(fgrants.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) check($sformatf("fp_grant%0d", i), 64'(fgrants[i]), 64'd0);
    ones = 0;
    foreach (fgrants[i]) if (fgrants[i] != 0) ones++;
    check("fp_port1_grants", 64'(ones), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
